// File: rtl/piso_frame_tx_if.sv
// rtl/piso_frame_tx_if.sv - parallel word handshake into the framing transmitter
interface piso_frame_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;

  modport master (output din, output din_valid, input  din_ready);
  modport slave  (input  din, input  din_valid, output din_ready);
endinterface

// File: rtl/piso_frame_tx.sv
// rtl/piso_frame_tx.sv - start/data/stop framing PISO transmitter
// Every output is a register whose next value is decoded from the next state.
module piso_frame_tx #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  piso_frame_tx_if.slave   s_if,
  output logic             sdo,
  output logic             busy,
  output logic             tx_done
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             sdo_q, sdo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             bit_end;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      sdo_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      sdo_q   <= sdo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    bit_end = (cyc_q == CYC_LAST);
    case (state_q)
      S_IDLE: begin
        if (s_if.din_valid && ready_q) begin
          state_d = S_START;
          shreg_d = s_if.din;
          cyc_d   = '0;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          cyc_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cyc_d   = '0;
          shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
          if (bit_q == BIT_LAST) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cyc_d   = '0;
          state_d = S_IDLE;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Registered outputs track the state being entered, so a handshake edge
    // already presents the start bit and drops din_ready.
    sdo_d = 1'b1;
    case (state_d)
      S_START: sdo_d = 1'b0;
      S_DATA:  sdo_d = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
      default: sdo_d = 1'b1;
    endcase
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
    done_d  = (state_d == S_STOP) && (cyc_d == CYC_LAST);
  end

  assign s_if.din_ready = ready_q;
  assign sdo            = sdo_q;
  assign busy           = busy_q;
  assign tx_done        = done_q;

endmodule

// File: tb/tb_piso_frame_tx.sv
// tb/tb_piso_frame_tx.sv - scoreboard bench for piso_frame_tx
module tb_piso_frame_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  piso_frame_tx_if #(.WIDTH(8)) if_a ();
  piso_frame_tx_if #(.WIDTH(8)) if_b ();
  piso_frame_tx_if #(.WIDTH(1)) if_c ();

  logic sdo_a, busy_a, done_a;
  logic sdo_b, busy_b, done_b;
  logic sdo_c, busy_c, done_c;

  piso_frame_tx #(.WIDTH(8), .BIT_CYCLES(1), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset_n(rst_n), .s_if(if_a.slave),
    .sdo(sdo_a), .busy(busy_a), .tx_done(done_a));
  piso_frame_tx #(.WIDTH(8), .BIT_CYCLES(3), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset_n(rst_n), .s_if(if_b.slave),
    .sdo(sdo_b), .busy(busy_b), .tx_done(done_b));
  piso_frame_tx #(.WIDTH(1), .BIT_CYCLES(1), .MSB_FIRST(1'b1)) dut_c (
    .clk(clk), .reset_n(rst_n), .s_if(if_c.slave),
    .sdo(sdo_c), .busy(busy_c), .tx_done(done_c));

  int n_chk = 0;
  int n_err = 0;
  logic [1:0] exp_q [3][$];   // {tx_done, sdo} per clock of an accepted frame
  logic rdy_model;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame(input int k, input logic [7:0] d, input int w, input int bc, input bit msb);
    logic b;
    for (int i = 0; i < w + 2; i++) begin
      if (i == 0) b = 1'b0;
      else if (i == w + 1) b = 1'b1;
      else b = msb ? d[w - i] : d[i - 1];
      for (int c = 0; c < bc; c++)
        exp_q[k].push_back({(i == w + 1) && (c == bc - 1), b});
    end
  endtask

  task automatic mon(input string nm, input int k, input logic sdo, input logic rdy, input logic bsy,
                     input logic dn, input logic vld, input logic [7:0] d,
                     input int w, input int bc, input bit msb);
    logic [1:0] e;
    if (!rst_n) begin
      chk({nm, ".rst_sdo"}, sdo, 1);
      chk({nm, ".rst_ready"}, rdy, 0);
      chk({nm, ".rst_busy"}, bsy, 0);
      chk({nm, ".rst_done"}, dn, 0);
      exp_q[k].delete();
    end else if (exp_q[k].size() != 0) begin
      e = exp_q[k].pop_front();
      chk({nm, ".sdo"}, sdo, e[0]);
      chk({nm, ".done"}, dn, e[1]);
      chk({nm, ".busy"}, bsy, 1);
      chk({nm, ".ready"}, rdy, 0);
    end else begin
      chk({nm, ".idle_sdo"}, sdo, 1);
      chk({nm, ".idle_busy"}, bsy, 0);
      chk({nm, ".idle_done"}, dn, 0);
      chk({nm, ".idle_ready"}, rdy, rdy_model);
      if (rdy_model && vld) push_frame(k, d, w, bc, msb);
    end
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) rdy_model <= 1'b0;
    else        rdy_model <= 1'b1;

  always @(negedge clk) mon("a", 0, sdo_a, if_a.din_ready, busy_a, done_a, if_a.din_valid, if_a.din, 8, 1, 1'b1);
  always @(negedge clk) mon("b", 1, sdo_b, if_b.din_ready, busy_b, done_b, if_b.din_valid, if_b.din, 8, 3, 1'b0);
  always @(negedge clk) mon("c", 2, sdo_c, if_c.din_ready, busy_c, done_c, if_c.din_valid, {7'd0, if_c.din}, 1, 1, 1'b1);

  task automatic wait_hs(input int k);
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (exp_q[k].size() == 0 && n < 200);
    if (exp_q[k].size() == 0) chk("hs_timeout", 1, 0);
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    while (exp_q[k].size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_q[k].size() != 0) chk("idle_timeout", 1, 0);
  endtask

  initial begin
    if_a.din = 8'hA5; if_a.din_valid = 1'b1;
    if_b.din = 8'h00; if_b.din_valid = 1'b0;
    if_c.din = 1'b0;  if_c.din_valid = 1'b0;
    #13 rst_n = 1'b1;

    // reset release with valid held, then A5 with busy-time disturbances
    wait_hs(0);
    #1 if_a.din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 if_a.din = 8'h3C; if_a.din_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 if_a.din_valid = 1'b0;
    @(posedge clk);
    #1 if_a.din_valid = 1'b1;
    @(posedge clk);
    #1 if_a.din_valid = 1'b0;
    wait_idle(0);

    // LSB first, 3 clocks per bit
    @(posedge clk);
    #1 if_b.din = 8'h01; if_b.din_valid = 1'b1;
    wait_hs(1);
    #1 if_b.din_valid = 1'b0;
    wait_idle(1);

    // back-to-back FF then 00 with valid held
    #1 if_a.din = 8'hFF; if_a.din_valid = 1'b1;
    wait_hs(0);
    #1 if_a.din = 8'h00;
    wait_idle(0);
    wait_hs(0);
    #1 if_a.din_valid = 1'b0;
    wait_idle(0);

    // single-bit frames
    #1 if_c.din = 1'b1; if_c.din_valid = 1'b1;
    wait_hs(2);
    #1 if_c.din = 1'b0;
    wait_idle(2);
    wait_hs(2);
    #1 if_c.din_valid = 1'b0;
    wait_idle(2);

    // reset during data bit 4, then a clean word
    #1 if_a.din = 8'h5A; if_a.din_valid = 1'b1;
    wait_hs(0);
    #1 if_a.din_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midrst_sdo", sdo_a, 1);
    chk("midrst_done", done_a, 0);
    chk("midrst_busy", busy_a, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 if_a.din = 8'hC3; if_a.din_valid = 1'b1;
    wait_hs(0);
    #1 if_a.din_valid = 1'b0;
    wait_idle(0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
